// File: rtl/less_distance.sv
// -----------------------------------------------------------------------------
// less_distance
//
// Picks whichever of two unsigned candidates (dataA, dataB) is closer to the
// reference value reff and registers it. A tie goes to dataB.
//
// The datapath is a set of bit-slice ripple cascades:
//   - Two absolute-difference units. Each holds a pair of S-stage ripple
//     borrow subtractors (reff - x and x - reff). The final borrow of
//     reff - x picks whichever result is non-negative.
//   - One S-stage magnitude comparator. It runs from MSB to LSB and passes
//     (lt, eq) status from cell to cell.
// The whole path settles in one cycle. The result sits behind a single
// register stage.
//
// Optional feature (macro LESS_DISTANCE_DIST_OUT_EN):
//   When defined, the block adds output port dist. It carries the registered
//   distance of the chosen candidate.
//
// Parameters:
//   S          operand/result width in bits (>= 2)
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   operands valid this cycle
//   reff       reference value
//   dataA      candidate A
//   dataB      candidate B
//   s          registered selected candidate
//   out_valid  s was updated by the previous edge
//   dist       registered winning distance (only with the macro)
// -----------------------------------------------------------------------------
module less_distance #(
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [S-1:0] reff,
    input  logic [S-1:0] dataA,
    input  logic [S-1:0] dataB,
    output logic [S-1:0] s,
`ifdef LESS_DISTANCE_DIST_OUT_EN
    output logic [S-1:0] dist,
`endif
    output logic         out_valid
);

    // Candidate operands indexed by unit: 0 -> A, 1 -> B.
    logic [S-1:0] cand [2];
    assign cand[0] = dataA;
    assign cand[1] = dataB;

    // Absolute distance per unit.
    logic [S-1:0] dist_abs [2];

    // ------------------------------------------------------------------
    // Absolute-difference units.
    // Each unit has two ripple borrow chains. Single-bit unpacked arrays
    // keep every stage an independent net.
    // ------------------------------------------------------------------
    genvar gi, gu;
    generate
        for (gu = 0; gu < 2; gu++) begin : g_absdiff
            logic         bor_rx [S+1];   // borrow chain of reff - x
            logic         bor_xr [S+1];   // borrow chain of x - reff
            logic [S-1:0] diff_rx;
            logic [S-1:0] diff_xr;

            assign bor_rx[0] = 1'b0;
            assign bor_xr[0] = 1'b0;

            for (gi = 0; gi < S; gi++) begin : g_cell
                logic a_rx, b_rx, a_xr, b_xr;
                assign a_rx = reff[gi];
                assign b_rx = cand[gu][gi];
                assign a_xr = cand[gu][gi];
                assign b_xr = reff[gi];

                assign diff_rx[gi]  = a_rx ^ b_rx ^ bor_rx[gi];
                assign bor_rx[gi+1] = (~a_rx & b_rx) | (~(a_rx ^ b_rx) & bor_rx[gi]);

                assign diff_xr[gi]  = a_xr ^ b_xr ^ bor_xr[gi];
                assign bor_xr[gi+1] = (~a_xr & b_xr) | (~(a_xr ^ b_xr) & bor_xr[gi]);
            end

            // A borrow out of reff - x means x > reff, so x - reff is the
            // non-negative difference.
            assign dist_abs[gu] = bor_rx[S] ? diff_xr : diff_rx;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Magnitude comparator, MSB to LSB: lt_c/eq_c[i] is the status after
    // examining bits S-1 down to i. Decides d1 < d2.
    // ------------------------------------------------------------------
    logic lt_c [S+1];
    logic eq_c [S+1];

    assign lt_c[S] = 1'b0;
    assign eq_c[S] = 1'b1;

    generate
        for (gi = S - 1; gi >= 0; gi--) begin : g_cmp
            logic a_bit, b_bit;
            assign a_bit    = dist_abs[0][gi];
            assign b_bit    = dist_abs[1][gi];
            assign lt_c[gi] = lt_c[gi+1] | (eq_c[gi+1] & ~a_bit & b_bit);
            assign eq_c[gi] = eq_c[gi+1] & ~(a_bit ^ b_bit);
        end
    endgenerate

    logic         pick_a;
    logic [S-1:0] sel_next;
    assign pick_a   = lt_c[0];              // strict: ties fall through to B
    assign sel_next = pick_a ? dataA : dataB;

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [S-1:0] s_reg;
    logic         out_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                s_reg <= sel_next;
            end
        end
    end

    assign s         = s_reg;
    assign out_valid = out_valid_reg;

`ifdef LESS_DISTANCE_DIST_OUT_EN
    logic [S-1:0] dist_next;
    logic [S-1:0] dist_reg;
    assign dist_next = pick_a ? dist_abs[0] : dist_abs[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            dist_reg <= '0;
        end else if (in_valid) begin
            dist_reg <= dist_next;
        end
    end

    assign dist = dist_reg;
`endif

endmodule

// File: tb/tb_less_distance.sv
// -----------------------------------------------------------------------------
// tb_less_distance
//
// Directed vectors with hand-computed results, then random vectors checked
// against a behavioural closest-value model. Build with
// LESS_DISTANCE_DIST_OUT_EN defined to also check the dist output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_less_distance;

    localparam int S = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [S-1:0] reff;
    logic [S-1:0] data_a;
    logic [S-1:0] data_b;
    logic [S-1:0] s;
    logic         out_valid;
`ifdef LESS_DISTANCE_DIST_OUT_EN
    logic [S-1:0] dist;
`endif

    int checks = 0;
    int errors = 0;

    less_distance #(.S(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .reff      (reff),
        .dataA     (data_a),
        .dataB     (data_b),
        .s         (s),
`ifdef LESS_DISTANCE_DIST_OUT_EN
        .dist      (dist),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge.
    task automatic step(input logic rst, input logic v,
                        input logic [S-1:0] r, input logic [S-1:0] a, input logic [S-1:0] b);
        reset    = rst;
        in_valid = v;
        reff     = r;
        data_a   = a;
        data_b   = b;
        @(posedge clk);
        #1;
        $display("txn rst=%0b v=%0b reff=%0d A=%0d B=%0d -> s=%0d out_valid=%0b",
                 rst, v, r, a, b, s, out_valid);
    endtask

    // Directed operation with expected select and distance.
    task automatic op(input string tag, input logic [S-1:0] r, input logic [S-1:0] a,
                      input logic [S-1:0] b, input logic [S-1:0] exp_s, input logic [S-1:0] exp_d);
        step(1'b0, 1'b1, r, a, b);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
`ifdef LESS_DISTANCE_DIST_OUT_EN
        check({tag, "_dist"}, 32'(dist), 32'(exp_d));
`else
        if (exp_d != exp_d) $display("unreachable");
`endif
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; reff = '0; data_a = '0; data_b = '0;

        // Reset state
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
`ifdef LESS_DISTANCE_DIST_OUT_EN
        check("rst_dist", 32'(dist), 32'd0);
`endif

        // Basic, extreme operands, ties, exact match
        op("basic",  8'd100, 8'd90,  8'd120, 8'd90,  8'd10);
        op("ext0",   8'd0,   8'd255, 8'd1,   8'd1,   8'd1);
        op("ext255", 8'd255, 8'd0,   8'd254, 8'd254, 8'd1);
        op("tie",    8'd50,  8'd40,  8'd60,  8'd60,  8'd10);
        op("same",   8'd3,   8'd7,   8'd7,   8'd7,   8'd4);
        op("exact",  8'd200, 8'd200, 8'd199, 8'd200, 8'd0);
        op("pickb",  8'd10,  8'd30,  8'd12,  8'd12,  8'd2);

        // Hold: load 90, then idle cycle with different operands
        op("hold_ld", 8'd100, 8'd90, 8'd120, 8'd90, 8'd10);
        step(1'b0, 1'b0, 8'd5, 8'd6, 8'd200);
        check("hold_s", 32'(s), 32'd90);
        check("hold_ov", 32'(out_valid), 32'd0);
`ifdef LESS_DISTANCE_DIST_OUT_EN
        check("hold_dist", 32'(dist), 32'd10);
`endif

        // Reset overrides a valid operation
        op("pre_rst", 8'd100, 8'd90, 8'd120, 8'd90, 8'd10);
        step(1'b1, 1'b1, 8'd100, 8'd90, 8'd120);
        check("rstop_s", 32'(s), 32'd0);
        check("rstop_ov", 32'(out_valid), 32'd0);
`ifdef LESS_DISTANCE_DIST_OUT_EN
        check("rstop_dist", 32'(dist), 32'd0);
`endif

        // Random vectors, back-to-back, against a behavioural model
        for (int i = 0; i < 200; i++) begin
            int r, a, b, d1, d2, es;
            r  = $urandom_range(0, 255);
            a  = $urandom_range(0, 255);
            b  = (i % 8 == 0) ? a : $urandom_range(0, 255);
            d1 = (r >= a) ? r - a : a - r;
            d2 = (r >= b) ? r - b : b - r;
            es = (d1 < d2) ? a : b;
            step(1'b0, 1'b1, 8'(r), 8'(a), 8'(b));
            check("rand_s", 32'(s), 32'(es));
            check("rand_ov", 32'(out_valid), 32'd1);
`ifdef LESS_DISTANCE_DIST_OUT_EN
            check("rand_dist", 32'(dist), 32'((d1 < d2) ? d1 : d2));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/less_distance.md
# less_distance

- Selects whichever of two unsigned operands, `dataA` or `dataB`, is numerically closer to a reference value `reff`, and registers the result.
- Built as an iterative bit-slice datapath: two absolute-difference units and one magnitude comparator, all ripple cascades.
- Used as a small RT-level selection component behind an input-valid strobe in larger datapaths.

## Interface

Parameters:
- `S`, default 8: operand and result width in bits; minimum 2.

Ports:
- `clk` in, 1: the single clock; all state updates on its rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: the operands are presented this cycle.
- `reff` in, S: unsigned reference value.
- `dataA` in, S: unsigned candidate A.
- `dataB` in, S: unsigned candidate B.
- `s` out, S: registered selected candidate.
- `out_valid` out, 1: `s` was updated by the previous edge.
- `dist` out, S: registered winning distance. Present only with `LESS_DISTANCE_DIST_OUT_EN`.

## Operation

- Compute the two distances:
  - `d1 = |reff - dataA|`
  - `d2 = |reff - dataB|`
- Arithmetic:
  - All values are unsigned, with no wrap-around.
  - Each distance is formed as the larger operand minus the smaller, so the result always fits in S bits.
- Selection rule:
  - If `d1 < d2` (strict), choose `dataA`.
  - Otherwise choose `dataB`.
  - On a tie (`d1 == d2`), choose `dataB`. This includes the case `dataA == dataB`.
- Structure:
  - Each absolute difference is an S-stage ripple borrow subtractor. Its final borrow chooses between `reff - x` and `x - reff`.
  - The comparator is an S-stage iterative cell chain running MSB to LSB, passing (lt, eq) status from stage to stage.
- Registers:
  - `s` loads the choice when `in_valid` = 1.
  - `s` holds its value when `in_valid` = 0.
  - `out_valid` loads `in_valid` every cycle.
- There is no state machine; the block is a single pipeline stage.

## Timing

- Latency is 1 cycle: operands sampled at edge N appear on `s` after edge N, with `out_valid` = 1 in that same cycle.
- Throughput is one operation per cycle. Back-to-back `in_valid` pulses are fully supported.
- Reset, when `reset` = 1 at an edge:
  - `s` = 0
  - `out_valid` = 0
  - `dist` = 0 (when present)
- Reset overrides `in_valid` at the same edge. An operation presented in the reset cycle is discarded.
- The combinational path (subtractors, comparator, mux) must settle within one clock period. No multicycle paths are allowed.
- There is no back-pressure; downstream logic must accept `s` whenever `out_valid` = 1.

## Configuration

- With `LESS_DISTANCE_DIST_OUT_EN` defined:
  - Port `dist` exists.
  - `dist` registers `d1` when A is chosen, `d2` otherwise.
  - `dist` loads and holds under the same rules as `s`.
- Without the macro, neither the `dist` port nor its register exists. `s` and `out_valid` behaviour is identical in both builds.

## Test plan

All scenarios use S = 8.
- `reff`=100, `dataA`=90, `dataB`=120, `in_valid`=1 -> next cycle `s`=90, `out_valid`=1, `dist`=10.
- `reff`=0, `dataA`=255, `dataB`=1 -> `s`=1; `reff`=255, `dataA`=0, `dataB`=254 -> `s`=254 (extreme operands, no wrap).
- Tie: `reff`=50, `dataA`=40, `dataB`=60 -> `s`=60, `dist`=10; `dataA`=`dataB`=7 -> `s`=7.
- Exact match: `reff`=200, `dataA`=200, `dataB`=199 -> `s`=200, `dist`=0.
- Hold: load 90 as in scenario 1, then `in_valid`=0 with new operands -> `s` stays 90, `out_valid`=0.
- Reset during operation: `reset`=1 with `in_valid`=1 and valid operands -> next cycle `s`=0, `out_valid`=0. Then release reset and run random vectors against the selection rule: zero mismatches.
